seq_detector_param: RTL and testbench

Parametrised Moore serial-pattern detector for the bit-stream FSM library. Matches a compile-time pattern of PATTERN_W bits, arriving MSB-first, with runtime-selectable overlapping or non-overlapping detection. Adds an input-valid qualifier and a saturating match counter. Drops in wherever a fixed-pattern sequence-detector FSM is used today.

---
 rtl/seq_det_pkg.sv | 39 +++
 rtl/seq_match_len.sv | 29 ++
 rtl/seq_detector_param.sv | 72 +++++++
 tb/tb_seq_detector_param.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised serial-pattern detector.
// Width helper, pattern-length legality check and prefix matcher.
package seq_det_pkg;

    localparam int MAX_W = 16;

    function automatic int len_w(input int pw);
        return $clog2(pw + 1);
    endfunction

    function automatic bit pattern_w_ok(input int pw);
        return (pw >= 2) && (pw <= MAX_W);
    endfunction

    // win[0] is the newest bit; returns the longest k <= cap whose last
    // k bits equal the first k bits of the pattern.
    function automatic int prefix_len(
        input logic [MAX_W-1:0] win,
        input logic [MAX_W-1:0] pat,
        input int               pw,
        input int               cap
    );
        int               best;
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] ref_bits;
        best = 0;
        for (int k = 1; k <= MAX_W; k++) begin
            if (k <= pw && k <= cap) begin
                mask     = MAX_W'((32'd1 << k) - 32'd1);
                ref_bits = pat >> (pw - k);
                if (((win ^ ref_bits) & mask) == '0) begin
                    best = k;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_match_len.sv
// Combinational next matched-prefix length for the pattern detector.
// Caps the search so the result never outruns the current match.
module seq_match_len
    import seq_det_pkg::*;
#(
    parameter int                 PW      = 4,
    parameter logic [PW-1:0]      PATTERN = 4'b1011,
    parameter int                 LW      = 3
) (
    input  logic [PW-2:0] hist,
    input  logic          din,
    input  logic [LW-1:0] len,
    input  logic          overlap,
    output logic [LW-1:0] next_len
);

    int cap;

    // Non-overlapping restart after a full match only looks at din.
    always_comb begin
        cap = int'(len) + 1;
        if (int'(len) == PW) begin
            cap = overlap ? PW : 1;
        end
        next_len = LW'(prefix_len(MAX_W'({hist, din}),
                                  MAX_W'(PATTERN), PW, cap));
    end

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector with valid qualifier, selectable
// overlap and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter int                   COUNT_W   = 8,
    localparam int                  LW        = len_w(PATTERN_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               in_valid,
    input  logic               overlap,
    input  logic               clr_count,
    output logic               detect,
    output logic [LW-1:0]      match_len,
    output logic [COUNT_W-1:0] match_count
);

    localparam int            HW   = PATTERN_W - 1;
    localparam logic [LW-1:0] FULL = LW'(PATTERN_W);

    if (!pattern_w_ok(PATTERN_W)) begin : g_bad_w
        $error("seq_detector_param: PATTERN_W must be 2..16");
    end
    if (COUNT_W < 1) begin : g_bad_cnt
        $error("seq_detector_param: COUNT_W must be >= 1");
    end

    logic [HW-1:0] hist;
    logic [LW-1:0] next_len;
    logic          hit;

    seq_match_len #(
        .PW      (PATTERN_W),
        .PATTERN (PATTERN),
        .LW      (LW)
    ) u_match (
        .hist     (hist),
        .din      (in),
        .len      (match_len),
        .overlap  (overlap),
        .next_len (next_len)
    );

    assign hit    = in_valid && (next_len == FULL);
    assign detect = (match_len == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_len <= '0;
            hist      <= '0;
        end else if (in_valid) begin
            match_len <= next_len;
            hist      <= HW'({hist, in});
        end
    end

    // Clear wins over a same-edge increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_count <= '0;
        end else if (clr_count) begin
            match_count <= '0;
        end else if (hit && (match_count != '1)) begin
            match_count <= match_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three configurations fed one stream,
// checked against a suffix/prefix reference model every cycle.
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in = 1'b0;
    logic in_valid = 1'b0;
    logic overlap = 1'b0;
    logic clr_count = 1'b0;

    always #5 clk = ~clk;

    logic       det0, det1, det2;
    logic [2:0] len0;
    logic [1:0] len1;
    logic [2:0] len2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_pat[3];
    logic [15:0] m_w[3];
    int          m_pw[3];
    int          m_cmax[3];
    int          m_n[3];
    int          m_l[3];
    int          m_c[3];

    seq_detector_param u0 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .overlap(overlap), .clr_count(clr_count),
        .detect(det0), .match_len(len0), .match_count(cnt0)
    );

    seq_detector_param #(
        .PATTERN_W(3), .PATTERN(3'b111)
    ) u1 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .overlap(overlap), .clr_count(clr_count),
        .detect(det1), .match_len(len1), .match_count(cnt1)
    );

    seq_detector_param #(
        .COUNT_W(2)
    ) u2 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid),
        .overlap(overlap), .clr_count(clr_count),
        .detect(det2), .match_len(len2), .match_count(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Longest suffix of the bits seen since the last restart that
    // equals a prefix of the pattern.
    function automatic int best_len(input int i);
        int  best;
        bit  ok;
        best = 0;
        for (int k = 1; k <= m_pw[i]; k++) begin
            ok = (k <= m_n[i]);
            for (int j = 0; j < k; j++) begin
                if (m_w[i][j] !== m_pat[i][m_pw[i] - k + j]) ok = 0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_w[i] = '0;
            m_n[i] = 0;
            m_l[i] = 0;
            m_c[i] = 0;
        end
    endtask

    task automatic model_step(input logic b, input logic v,
                              input logic ov, input logic clr);
        for (int i = 0; i < 3; i++) begin
            if (v) begin
                if (m_l[i] == m_pw[i] && !ov) m_n[i] = 0;
                m_w[i] = {m_w[i][14:0], b};
                if (m_n[i] < 16) m_n[i]++;
                m_l[i] = best_len(i);
            end
            if (clr) m_c[i] = 0;
            else if (v && m_l[i] == m_pw[i] && m_c[i] < m_cmax[i]) m_c[i]++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " u0.len"}, 32'(len0), 32'(m_l[0]));
        chk({tag, " u0.det"}, 32'(det0), 32'(m_l[0] == m_pw[0]));
        chk({tag, " u0.cnt"}, 32'(cnt0), 32'(m_c[0]));
        chk({tag, " u1.len"}, 32'(len1), 32'(m_l[1]));
        chk({tag, " u1.det"}, 32'(det1), 32'(m_l[1] == m_pw[1]));
        chk({tag, " u1.cnt"}, 32'(cnt1), 32'(m_c[1]));
        chk({tag, " u2.len"}, 32'(len2), 32'(m_l[2]));
        chk({tag, " u2.det"}, 32'(det2), 32'(m_l[2] == m_pw[2]));
        chk({tag, " u2.cnt"}, 32'(cnt2), 32'(m_c[2]));
    endtask

    task automatic step(input logic b, input logic v,
                        input logic ov, input logic clr);
        in = b;
        in_valid = v;
        overlap = ov;
        clr_count = clr;
        @(posedge clk);
        model_step(b, v, ov, clr);
        #1;
        check_all("step");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] bits, input int n,
                        input logic ov);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, ov, 1'b0);
    endtask

    initial begin
        m_pat[0] = 16'b1011; m_pw[0] = 4; m_cmax[0] = 255;
        m_pat[1] = 16'b111;  m_pw[1] = 3; m_cmax[1] = 255;
        m_pat[2] = 16'b1011; m_pw[2] = 4; m_cmax[2] = 3;
        model_reset();
        #2;
        do_reset();
        chk("reset det0", 32'(det0), 0);

        // non-overlapping 1011011
        send(32'b1011, 4, 1'b0);
        chk("t1 det after bit4", 32'(det0), 1);
        send(32'b011, 3, 1'b0);
        chk("t1 count", 32'(cnt0), 1);
        chk("t1 final len", 32'(len0), 1);
        chk("t1 final det", 32'(det0), 0);

        do_reset();
        send(32'b1011011, 7, 1'b1);
        chk("t2 det after bit7", 32'(det0), 1);
        chk("t2 count", 32'(cnt0), 2);

        do_reset();
        send(32'b111111, 6, 1'b1);
        chk("t3 ov count", 32'(cnt1), 4);
        do_reset();
        send(32'b111111, 6, 1'b0);
        chk("t3 nov count", 32'(cnt1), 2);

        // valid gap holds state
        do_reset();
        send(32'b10, 2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4 gap len", 32'(len0), 2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4 gap len end", 32'(len0), 2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4 no early det", 32'(det0), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4 det", 32'(det0), 1);

        // saturation and clear priority
        do_reset();
        send(32'b1011011011011, 13, 1'b1);
        chk("t5 sat count", 32'(cnt2), 3);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t5 clr count", 32'(cnt2), 0);
        chk("t5 clr det", 32'(det2), 1);

        // async reset mid-match
        do_reset();
        send(32'b101, 3, 1'b0);
        do_reset();
        chk("t6 rst len", 32'(len0), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6 len after", 32'(len0), 1);
        chk("t6 det after", 32'(det0), 0);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom), $urandom_range(9) < 8,
                     1'($urandom), $urandom_range(19) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
